// File: rtl/pe_tile_sequencer.sv
// Sequencer for one 7-row x 4-lane PE dot-product tile: accepts operand chunks, drives the PE, accumulates rows.
// Optional PE_TILE_RELU_EN: the result port applies ReLU per row; internal accumulators are untouched.
module pe_tile_sequencer #(
   parameter int MAX_CHUNKS = 256
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [8:0]     num_chunks,
   input  logic [31:0]    bias_in,
   input  logic           chunk_valid,
   output logic           chunk_ready,
   input  logic [223:0]   chunk_act,
   input  logic [31:0]    chunk_w,
   output logic [223:0]   pe_in,
   output logic [31:0]    pe_w,
   output logic [31:0]    pe_bias,
   input  logic [223:0]   pe_out,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [223:0]   res_data,
   output logic           busy,
   output logic           done
);
   // state | meaning
   // IDLE  | waiting for start
   // LOAD  | accepting operand chunks; accumulation trails each accept by one cycle
   // FLUSH | final accumulate of the last accepted chunk
   // OUT   | result held on res_data until res_ready
   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, OUT} state_t;

   localparam int CW = $clog2(MAX_CHUNKS + 1);

   state_t        state;
   logic [CW-1:0] num_q;
   logic [CW-1:0] count;
   logic [CW-1:0] count_inc;
   logic [CW-1:0] num_clamped;
   logic [31:0]   bias_q;
   logic          first_flag;
   logic          op_vld;
   logic          op_first;
   logic [31:0]   acc     [7];
   logic [31:0]   acc_nxt [7];

   always_comb begin
      num_clamped = (32'(num_chunks) > 32'(MAX_CHUNKS)) ? CW'(MAX_CHUNKS) : CW'(num_chunks);
      count_inc   = count + 1'b1;
   end

   // The first chunk overwrites the bias preload: its PE pass already carries the bias.
   always_comb begin
      for (int i = 0; i < 7; i++) begin
         acc_nxt[i] = op_first ? pe_out[i*32 +: 32] : acc[i] + pe_out[i*32 +: 32];
      end
   end

   always_comb begin
      res_data = '0;
      if (res_valid) begin
         for (int i = 0; i < 7; i++) begin
`ifdef PE_TILE_RELU_EN
            res_data[i*32 +: 32] = acc[i][31] ? 32'd0 : acc[i];
`else
            res_data[i*32 +: 32] = acc[i];
`endif
         end
      end
   end

   assign done = res_valid & res_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         chunk_ready <= 1'b0;
         res_valid   <= 1'b0;
         busy        <= 1'b0;
         pe_in       <= '0;
         pe_w        <= '0;
         pe_bias     <= '0;
         num_q       <= '0;
         count       <= '0;
         bias_q      <= '0;
         first_flag  <= 1'b0;
         op_vld      <= 1'b0;
         op_first    <= 1'b0;
         for (int i = 0; i < 7; i++) acc[i] <= '0;
      end else begin
         op_vld <= 1'b0;
         if (op_vld) begin
            for (int i = 0; i < 7; i++) acc[i] <= acc_nxt[i];
         end
         case (state)
            IDLE: begin
               if (start) begin
                  num_q       <= num_clamped;
                  bias_q      <= bias_in;
                  count       <= '0;
                  first_flag  <= 1'b1;
                  chunk_ready <= (num_clamped != '0);
                  busy        <= 1'b1;
                  state       <= LOAD;
                  for (int i = 0; i < 7; i++) acc[i] <= bias_in;
               end
            end
            LOAD: begin
               if (chunk_valid && chunk_ready) begin
                  pe_in      <= chunk_act;
                  pe_w       <= chunk_w;
                  pe_bias    <= first_flag ? bias_q : 32'd0;
                  op_vld     <= 1'b1;
                  op_first   <= first_flag;
                  first_flag <= 1'b0;
                  count      <= count_inc;
                  if (count_inc == num_q) begin
                     chunk_ready <= 1'b0;
                     state       <= FLUSH;
                  end
               end else if (count == num_q) begin
                  res_valid <= 1'b1;
                  state     <= OUT;
               end
            end
            FLUSH: begin
               res_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pe_tile_sequencer.sv
// Scoreboard bench for pe_tile_sequencer with a behavioural PE block (row = sum(act*w) + bias).
module tb_pe_tile_sequencer;
   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [8:0]   num_chunks;
   logic [31:0]  bias_in;
   logic         chunk_valid;
   logic         chunk_ready;
   logic [223:0] chunk_act;
   logic [31:0]  chunk_w;
   logic [223:0] pe_in;
   logic [31:0]  pe_w;
   logic [31:0]  pe_bias;
   logic [223:0] pe_out;
   logic         res_valid;
   logic         res_ready;
   logic [223:0] res_data;
   logic         busy;
   logic         done;

   int n_tests = 0;
   int n_fail  = 0;
   logic [223:0] exp_q[$];

   pe_tile_sequencer #(.MAX_CHUNKS(256)) dut (
      .clk(clk), .rst(rst), .start(start), .num_chunks(num_chunks), .bias_in(bias_in),
      .chunk_valid(chunk_valid), .chunk_ready(chunk_ready), .chunk_act(chunk_act), .chunk_w(chunk_w),
      .pe_in(pe_in), .pe_w(pe_w), .pe_bias(pe_bias), .pe_out(pe_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pe_row(input logic [223:0] a, input logic [31:0] w,
                                          input logic [31:0] b, input int i);
      logic signed [31:0] s;
      s = $signed(b);
      for (int j = 0; j < 4; j++)
         s = s + 32'($signed(a[(i*4+j)*8 +: 8])) * 32'($signed(w[j*8 +: 8]));
      return s;
   endfunction

   always_comb begin
      pe_out = '0;
      for (int i = 0; i < 7; i++) pe_out[i*32 +: 32] = pe_row(pe_in, pe_w, pe_bias, i);
   end

   function automatic logic [223:0] act_const(input logic [7:0] v);
      logic [223:0] r;
      for (int k = 0; k < 28; k++) r[k*8 +: 8] = v;
      return r;
   endfunction

   function automatic logic [223:0] act_rowidx();
      logic [223:0] r;
      for (int i = 0; i < 7; i++)
         for (int j = 0; j < 4; j++) r[(i*4+j)*8 +: 8] = 8'(i + 1);
      return r;
   endfunction

   function automatic logic [223:0] act_laneidx();
      logic [223:0] r;
      for (int i = 0; i < 7; i++)
         for (int j = 0; j < 4; j++) r[(i*4+j)*8 +: 8] = 8'(j + 1);
      return r;
   endfunction

   function automatic logic [223:0] rows_const(input logic [31:0] v);
      logic [223:0] r;
      for (int i = 0; i < 7; i++) r[i*32 +: 32] = v;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [223:0] got, input logic [223:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   // Monitor: every result handshake pops one expected result.
   always @(negedge clk) begin
      #2;
      if (!rst && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", res_data, '0);
            n_fail++;
            $display("FAIL scoreboard_empty got=result exp=none");
         end else begin
            chk("res_data", res_data, exp_q.pop_front());
         end
         chk("done_on_handshake", 224'(done), 224'(1));
      end
   end

   task automatic start_job(input logic [8:0] n, input logic [31:0] b);
      start = 1'b1; num_chunks = n; bias_in = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_valid(output int cyc, output int accepts);
      cyc = 1; accepts = 0;
      while (!res_valid && cyc < 600) begin
         if (chunk_valid && chunk_ready) accepts++;
         @(negedge clk);
         cyc++;
      end
      if (!res_valid) begin
         n_tests++; n_fail++;
         $display("FAIL res_valid_timeout got=0 exp=1 after %0d cycles", cyc);
      end
   endtask

   task automatic handshake(input logic [223:0] exp, input logic with_start);
      chk("done_before_handshake", 224'(done), 224'(0));
      exp_q.push_back(exp);
      res_ready = 1'b1;
      start = with_start;
      @(negedge clk);
      res_ready = 1'b0;
      start = 1'b0;
      chk("idle_after_handshake", {222'(0), busy, res_valid}, '0);
      chk("done_after_handshake", 224'(done), 224'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, acc_n;
      logic [223:0] exp;
      logic [7:0] pat [8];
      rst = 1'b1; start = 1'b0; num_chunks = '0; bias_in = '0;
      chunk_valid = 1'b0; chunk_act = '0; chunk_w = '0; res_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_ctrl", {220'(0), busy, chunk_ready, res_valid, done}, '0);
      chk("reset_pe_in", pe_in, '0);
      chk("reset_pe_w_bias", {160'(0), pe_w, pe_bias}, '0);

      // 1: two chunks, valid held
      chunk_valid = 1'b1; chunk_act = act_const(8'd1); chunk_w = {4{8'd2}};
      start_job(9'd2, 32'd100);
      wait_valid(cyc, acc_n);
      chunk_valid = 1'b0;
      chk("t1_latency", 224'(cyc), 224'(4));
      chk("t1_accepts", 224'(acc_n), 224'(2));
      handshake(rows_const(32'd116), 1'b0);

      // 2: zero chunks
      chunk_valid = 1'b1;
      start_job(9'd0, 32'h0000_0005);
      wait_valid(cyc, acc_n);
      chunk_valid = 1'b0;
      chk("t2_latency", 224'(cyc), 224'(2));
      chk("t2_no_ready", 224'(acc_n), 224'(0));
      handshake(rows_const(32'd5), 1'b0);

      // 3: three chunks with gaps
      pat = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd1, 8'd1};
      chunk_act = act_rowidx(); chunk_w = {4{8'd1}};
      start_job(9'd3, 32'd10);
      acc_n = 0;
      for (int k = 0; k < 8; k++) begin
         chunk_valid = pat[k][0];
         if (chunk_valid && chunk_ready) acc_n++;
         @(negedge clk);
      end
      chunk_valid = 1'b0;
      chk("t3_accepts", 224'(acc_n), 224'(3));
      chk("t3_ready_low", 224'(chunk_ready), 224'(0));
      wait_valid(cyc, acc_n);
      for (int i = 0; i < 7; i++) exp[i*32 +: 32] = 32'(10 + 12 * (i + 1));
      handshake(exp, 1'b0);

      // 4: reset mid-job, then a clean job
      chunk_act = act_const(8'd3); chunk_w = {4{8'd3}};
      start_job(9'd3, 32'd7);
      chunk_valid = 1'b1;
      @(negedge clk);
      chunk_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t4_rst_ctrl", {220'(0), busy, chunk_ready, res_valid, done}, '0);
      chk("t4_rst_pe_in", pe_in, '0);
      chk("t4_rst_pe_w_bias", {160'(0), pe_w, pe_bias}, '0);
      chk("t4_rst_res_data", res_data, '0);
      chunk_act = act_laneidx(); chunk_w = {4{8'd1}}; chunk_valid = 1'b1;
      start_job(9'd1, 32'd3);
      wait_valid(cyc, acc_n);
      chunk_valid = 1'b0;
      chk("t4_latency", 224'(cyc), 224'(3));
      handshake(rows_const(32'd13), 1'b0);

      // 5: result held under back-pressure while start/chunk_valid pulse
      chunk_act = act_const(8'd2); chunk_w = {4{8'd3}}; chunk_valid = 1'b1;
      start_job(9'd1, 32'd1000);
      wait_valid(cyc, acc_n);
      chunk_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         start = (k % 2 == 0); num_chunks = 9'd2; chunk_valid = (k % 2 == 1);
         @(negedge clk);
         chk("t5_hold_data", res_data, rows_const(32'd1024));
         chk("t5_hold_ctrl", {220'(0), busy, chunk_ready, res_valid, done}, 224'(4'b1010));
      end
      start = 1'b0; chunk_valid = 1'b0;
      handshake(rows_const(32'd1024), 1'b1);

      // 6: negative bias, ReLU-dependent result
      chunk_act = act_const(8'd1); chunk_w = {4{8'd1}}; chunk_valid = 1'b1;
      start_job(9'd1, 32'hFFFF_FF00);
      wait_valid(cyc, acc_n);
      chunk_valid = 1'b0;
`ifdef PE_TILE_RELU_EN
      handshake(rows_const(32'd0), 1'b0);
`else
      handshake(rows_const(32'hFFFF_FF04), 1'b0);
`endif

      // 7: chunk count above MAX_CHUNKS is clamped to 256
      chunk_act = act_const(8'd1); chunk_w = {4{8'd1}}; chunk_valid = 1'b1;
      start_job(9'd300, 32'd0);
      wait_valid(cyc, acc_n);
      chunk_valid = 1'b0;
      chk("t7_accepts", 224'(acc_n), 224'(256));
      chk("t7_latency", 224'(cyc), 224'(258));
      handshake(rows_const(32'd1024), 1'b0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 224'(exp_q.size()), 224'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
